// File: rtl/i2s_stereo_recorder.sv
// rtl/i2s_stereo_recorder.sv - I2S stereo capture engine with valid/ready sample output
//
// Deserialises DATA_W-bit samples from the left/right LRC slots (BCLK domain)
// and presents them one at a time, tagged with channel and sequential address.
//
// Build option: define I2S_RX_LJ_MODE_EN for left-justified framing (no delay
// bit); leave it undefined for standard I2S with a 1-bit delay.
//
// Ports:
//   i_clk       codec BCLK, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_lrc       ADCLRCK, 0 = left slot, 1 = right slot
//   i_data      ADCDAT serial data, MSB first
//   i_ch_en     bit0 = capture left, bit1 = capture right
//   i_start     control pulse: begin / resume capture
//   i_pause     control pulse: suspend capture, keep address
//   i_stop      control pulse: return to idle, clear address
//   i_ready     downstream accepts the held sample this cycle
//   o_valid     a sample is held on o_data/o_ch/o_addr
//   o_data      captured sample, raw two's complement
//   o_ch        channel of o_data (0 = left, 1 = right)
//   o_addr      address for o_data
//   o_ovf       sticky: a completed sample was dropped
//   o_full      address space exhausted
//   o_busy      state is S_SYNC or S_RUN
module i2s_stereo_recorder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic [1:0]        i_ch_en,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ch,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_ovf,
  output logic              o_full,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_RUN,
    S_PAUSE,
    S_FULL
  } state_t;

  state_t             state_q, state_d;
  logic               lrc_q;
  logic [CNT_W-1:0]   bcnt_q;
  logic [DATA_W-2:0]  shift_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               slot_edge;
  logic               fall_edge;
  logic               run_like;
  logic               cap_slot;
  logic [CNT_W-1:0]   eff_cnt;
  logic [DATA_W-2:0]  eff_shift;
  logic               capture;
  logic               complete;
  logic               xfer;
  logic               xfer_last;
  logic               load;
  logic               drop;
  logic               idle_start;

  assign slot_edge = i_lrc ^ lrc_q;
  assign fall_edge = slot_edge & ~i_lrc;

  // The falling edge that moves S_SYNC to S_RUN already belongs to the first
  // left slot; in left-justified framing it carries the MSB, so treat it as a
  // running cycle for capture purposes.
  assign run_like = (state_q == S_RUN) | ((state_q == S_SYNC) & fall_edge);

`ifdef I2S_RX_LJ_MODE_EN
  assign cap_slot = 1'b1;
`else
  assign cap_slot = ~slot_edge;  // edge cycle is the I2S delay bit
`endif

  // A slot edge restarts the word: view counter and shifter as empty.
  assign eff_cnt   = slot_edge ? '0 : bcnt_q;
  assign eff_shift = slot_edge ? '0 : shift_q;

  assign capture   = run_like & i_ch_en[i_lrc] & cap_slot & (eff_cnt < CNT_MAX)
                   & ~i_stop & ~i_pause;
  assign complete  = capture & (eff_cnt == CNT_LAST);
  assign xfer      = o_valid & i_ready;
  assign xfer_last = xfer & (&addr_q);
  // Once the last address transfers, capture ends even for a coinciding word.
  assign load      = complete & (~o_valid | i_ready) & ~xfer_last;
  assign drop      = complete & o_valid & ~i_ready;
  assign idle_start = (state_q == S_IDLE) & i_start & ~i_stop;

  assign o_busy = (state_q == S_SYNC) | (state_q == S_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_start) state_d = S_SYNC;
        S_SYNC: begin
          if (i_pause)        state_d = S_PAUSE;
          else if (fall_edge) state_d = S_RUN;
        end
        S_RUN:   if (i_pause) state_d = S_PAUSE;
        S_PAUSE: if (i_start) state_d = S_SYNC;
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
      if (xfer_last) state_d = S_FULL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q   <= 1'b0;
      bcnt_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= 1'b0;
      o_addr  <= '0;
      o_ovf   <= 1'b0;
      o_full  <= 1'b0;
    end else begin
      lrc_q <= i_lrc;

      if (i_stop | i_pause) begin
        bcnt_q  <= '0;
        shift_q <= '0;
      end else if (capture) begin
        bcnt_q  <= eff_cnt + CNT_W'(1);
        shift_q <= {eff_shift[DATA_W-3:0], i_data};
      end else if (slot_edge) begin
        bcnt_q  <= '0;
        shift_q <= '0;
      end

      if (i_stop) begin
        o_valid <= 1'b0;
      end else if (load) begin
        o_valid <= 1'b1;
        o_data  <= {eff_shift, i_data};
        o_ch    <= i_lrc;
        // On a back-to-back transfer the counter advances this same edge.
        o_addr  <= xfer ? addr_q + ADDR_W'(1) : addr_q;
      end else if (xfer) begin
        o_valid <= 1'b0;
      end

      if (i_stop || idle_start) begin
        addr_q <= '0;
      end else if (xfer && !xfer_last) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      if (idle_start) begin
        o_ovf <= 1'b0;
      end else if (drop) begin
        o_ovf <= 1'b1;
      end

      if (idle_start) begin
        o_full <= 1'b0;
      end else if (xfer_last && !i_stop) begin
        o_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_recorder.sv
// tb/tb_i2s_stereo_recorder.sv - scoreboard bench for i2s_stereo_recorder
module tb_i2s_stereo_recorder;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int P_NONE  = 0;
  localparam int P_START = 1;
  localparam int P_PAUSE = 2;
  localparam int P_STOP  = 3;

`ifdef I2S_RX_LJ_MODE_EN
  localparam int OFS = 0;
`else
  localparam int OFS = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          lrc;
  logic          data;
  logic [1:0]    ch_en;
  logic          start;
  logic          pause;
  logic          stop;
  logic          ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_ch;
  logic [AW-1:0] o_addr;
  logic          o_ovf;
  logic          o_full;
  logic          o_busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ch;
    logic [AW-1:0] addr;
  } smp_t;

  smp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  i2s_stereo_recorder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_lrc   (lrc),
    .i_data  (data),
    .i_ch_en (ch_en),
    .i_start (start),
    .i_pause (pause),
    .i_stop  (stop),
    .i_ready (ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ch    (o_ch),
    .o_addr  (o_addr),
    .o_ovf   (o_ovf),
    .o_full  (o_full),
    .o_busy  (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic c, input logic [AW-1:0] a);
    smp_t s;
    s.data = d;
    s.ch   = c;
    s.addr = a;
    exp_q.push_back(s);
  endtask

  // One slot of len BCLKs at level l carrying w; optional control pulse at cycle pat.
  task automatic send_slot(input logic l, input logic [DW-1:0] w, input int len,
                           input int pat, input int kind);
    for (int i = 0; i < len; i++) begin
      int idx;
      idx   = i - OFS;
      lrc   = l;
      data  = (idx >= 0 && idx < DW) ? w[DW-1-idx] : 1'b0;
      start = (i == pat) && (kind == P_START);
      pause = (i == pat) && (kind == P_PAUSE);
      stop  = (i == pat) && (kind == P_STOP);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got data=0x%0h ch=%0d addr=%0d expected none",
                 o_data, o_ch, o_addr);
      end else begin
        smp_t e;
        e = exp_q.pop_front();
        check("sample_data", 32'(o_data), 32'(e.data));
        check("sample_ch",   32'(o_ch),   32'(e.ch));
        check("sample_addr", 32'(o_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    lrc   = 1'b0;
    data  = 1'b0;
    ch_en = 2'b11;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    ready = 1'b1;
    #3;
    check("reset_outputs", {o_valid, o_ch, o_ovf, o_full, o_busy, 27'(o_addr)}, 32'h0);
    check("reset_data", 32'(o_data), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Stereo capture: start while idle, right slot skipped in sync
    send_slot(1'b0, '0, 4, 1, P_START);
    check("sync_busy", 32'(o_busy), 32'h1);
    send_slot(1'b1, 16'hFFFF, 32, -1, P_NONE);
    push(16'hA5C3, 1'b0, 3'd0);
    send_slot(1'b0, 16'hA5C3, 32, -1, P_NONE);
    push(16'h1234, 1'b1, 3'd1);
    send_slot(1'b1, 16'h1234, 32, -1, P_NONE);
    check("stereo_ovf", 32'(o_ovf), 32'h0);

    // Mid-frame start: stop, then start inside a right slot
    send_slot(1'b1, '0, 4, 0, P_STOP);
    check("stop_busy", 32'(o_busy), 32'h0);
    send_slot(1'b1, 16'hFFFF, 32, 5, P_START);
    push(16'h0F0F, 1'b0, 3'd0);
    send_slot(1'b0, 16'h0F0F, 32, -1, P_NONE);
    push(16'h8001, 1'b1, 3'd1);
    send_slot(1'b1, 16'h8001, 32, -1, P_NONE);

    // Backpressure over one frame: left held, right dropped
    ready = 1'b0;
    push(16'h1111, 1'b0, 3'd2);
    send_slot(1'b0, 16'h1111, 32, -1, P_NONE);
    check("bp_valid_held", 32'(o_valid), 32'h1);
    check("bp_data_held", 32'(o_data), 32'h1111);
    send_slot(1'b1, 16'h2222, 32, -1, P_NONE);
    check("bp_data_stable", 32'(o_data), 32'h1111);
    ready = 1'b1;
    push(16'h3333, 1'b0, 3'd3);
    send_slot(1'b0, 16'h3333, 32, -1, P_NONE);
    check("bp_ovf", 32'(o_ovf), 32'h1);
    push(16'h4444, 1'b1, 3'd4);
    send_slot(1'b1, 16'h4444, 32, -1, P_NONE);
    push(16'h5555, 1'b0, 3'd5);
    send_slot(1'b0, 16'h5555, 32, -1, P_NONE);

    // Pause mid-word after address 5, then resume
    send_slot(1'b1, 16'h6666, 32, 8, P_PAUSE);
    check("pause_busy", 32'(o_busy), 32'h0);
    send_slot(1'b1, '0, 4, 0, P_START);
    push(16'h7777, 1'b0, 3'd6);
    send_slot(1'b0, 16'h7777, 32, -1, P_NONE);

    // Address 7 is the last one
    push(16'h8888, 1'b1, 3'd7);
    send_slot(1'b1, 16'h8888, 32, -1, P_NONE);
    check("full_flag", 32'(o_full), 32'h1);
    check("full_busy", 32'(o_busy), 32'h0);
    send_slot(1'b0, 16'h9999, 32, -1, P_NONE);
    send_slot(1'b1, 16'hAAAA, 32, -1, P_NONE);
    send_slot(1'b1, '0, 4, 0, P_STOP);
    check("stop_keeps_flags", {30'h0, o_full, o_ovf}, 32'h3);
    check("stop_valid", 32'(o_valid), 32'h0);
    send_slot(1'b1, '0, 4, 0, P_START);
    check("start_clears_flags", {30'h0, o_full, o_ovf}, 32'h0);
    push(16'hABCD, 1'b0, 3'd0);
    send_slot(1'b0, 16'hABCD, 32, -1, P_NONE);

    // Short right slot yields nothing
    send_slot(1'b1, 16'hFFFF, 10, -1, P_NONE);
    push(16'h0102, 1'b0, 3'd1);
    send_slot(1'b0, 16'h0102, 32, -1, P_NONE);

    // Right channel disabled
    ch_en = 2'b01;
    send_slot(1'b1, 16'hEEEE, 32, -1, P_NONE);
    push(16'h0304, 1'b0, 3'd2);
    send_slot(1'b0, 16'h0304, 32, -1, P_NONE);
    send_slot(1'b1, 16'h5A5A, 32, -1, P_NONE);

    check("all_expected_seen", 32'(exp_q.size()), 32'h0);
    check("final_ovf", 32'(o_ovf), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
